mem_access_unit: RTL

- Parametrised MEM-stage load/store unit, successor to the combinational byte-select/extend logic.
- Drives an SRAM-like split handshake bus (req/addr_ok/data_ok) with a configurable bus width, and stalls the pipeline while an access is outstanding.
- Owns address-error detection, byte strobes, sub-word extraction with sign or zero extension, and flush-safe draining of accepted requests.
- Sits between the EX/MEM pipeline register and the data-side bus bridge.

---
 rtl/mem_access_unit_pkg.sv | 60 ++++++
 rtl/mem_access_unit_align.sv | 98 +++++++++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM state
// encodings, bus size codes and op-decode helpers.
// Optional feature macro: UNALIGNED_LR_EN (enables LWL/LWR/SWL/SWR).
package mem_access_unit_pkg;

  // Memory op codes (MIPS primary opcode values)
  localparam logic [5:0] EXE_LB_OP  = 6'h20;
  localparam logic [5:0] EXE_LH_OP  = 6'h21;
  localparam logic [5:0] EXE_LWL_OP = 6'h22;
  localparam logic [5:0] EXE_LW_OP  = 6'h23;
  localparam logic [5:0] EXE_LBU_OP = 6'h24;
  localparam logic [5:0] EXE_LHU_OP = 6'h25;
  localparam logic [5:0] EXE_LWR_OP = 6'h26;
  localparam logic [5:0] EXE_SB_OP  = 6'h28;
  localparam logic [5:0] EXE_SH_OP  = 6'h29;
  localparam logic [5:0] EXE_SWL_OP = 6'h2A;
  localparam logic [5:0] EXE_SW_OP  = 6'h2B;
  localparam logic [5:0] EXE_SWR_OP = 6'h2E;

  // Access FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Bus size codes
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

`ifdef UNALIGNED_LR_EN
  localparam bit LR_EN = 1'b1;
`else
  localparam bit LR_EN = 1'b0;
`endif

  // Partial-word ops; when disabled they decode as non-memory ops
  function automatic logic op_is_lr(input logic [5:0] op);
    return LR_EN && (op inside {EXE_LWL_OP, EXE_LWR_OP, EXE_SWL_OP, EXE_SWR_OP});
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return (op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP}) ||
           (LR_EN && (op inside {EXE_LWL_OP, EXE_LWR_OP}));
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP}) ||
           (LR_EN && (op inside {EXE_SWL_OP, EXE_SWR_OP}));
  endfunction

  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
      default:                          return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational byte-lane unit: store strobes and replicated store data,
// load extraction with sign/zero extension, and LWL/LWR merge.
// Partial-word ops are only decoded when UNALIGNED_LR_EN is defined.
module mem_access_unit_align #(
  parameter int BUS_W = 32
) (
  input  logic [5:0]                   op,
  input  logic [$clog2(BUS_W/8)-1:0]   ofs,
  input  logic [31:0]                  wdata,
  input  logic [31:0]                  rt_old,
  input  logic [BUS_W-1:0]             rdata,
  output logic [BUS_W/8-1:0]           wstrb,
  output logic [BUS_W-1:0]             wdata_bus,
  output logic [31:0]                  ld_result
);
  import mem_access_unit_pkg::*;

  localparam int LANES = BUS_W / 8;
  localparam int OFS_W = $clog2(LANES);

  logic [OFS_W-1:0] lane_base;
  logic [31:0]      word_lane;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  // Byte offset of the 32-bit lane that holds the addressed byte
  assign lane_base = ofs & ~OFS_W'(3);
  assign word_lane = 32'(rdata >> {lane_base, 3'b000});
  assign byte_v    = 8'(word_lane >> {ofs[1:0], 3'b000});
  assign half_v    = 16'(word_lane >> {ofs[1], 4'b0000});

  // Store strobes and lane-replicated store data
  always_comb begin
    wstrb     = '0;
    wdata_bus = '0;
    case (op)
      EXE_SB_OP: begin
        wstrb     = LANES'(1) << ofs;
        wdata_bus = {LANES{wdata[7:0]}};
      end
      EXE_SH_OP: begin
        wstrb     = LANES'(3) << ofs;
        wdata_bus = {(LANES/2){wdata[15:0]}};
      end
      EXE_SW_OP: begin
        wstrb     = LANES'(15) << ofs;
        wdata_bus = {(LANES/4){wdata}};
      end
      EXE_SWL_OP: if (LR_EN) begin
        case (ofs[1:0])
          2'd0:    begin wstrb = LANES'(4'b0001) << lane_base; wdata_bus = {(LANES/4){24'h0, wdata[31:24]}}; end
          2'd1:    begin wstrb = LANES'(4'b0011) << lane_base; wdata_bus = {(LANES/4){16'h0, wdata[31:16]}}; end
          2'd2:    begin wstrb = LANES'(4'b0111) << lane_base; wdata_bus = {(LANES/4){8'h0, wdata[31:8]}}; end
          default: begin wstrb = LANES'(4'b1111) << lane_base; wdata_bus = {(LANES/4){wdata}}; end
        endcase
      end
      EXE_SWR_OP: if (LR_EN) begin
        case (ofs[1:0])
          2'd0:    begin wstrb = LANES'(4'b1111) << lane_base; wdata_bus = {(LANES/4){wdata}}; end
          2'd1:    begin wstrb = LANES'(4'b1110) << lane_base; wdata_bus = {(LANES/4){wdata[23:0], 8'h0}}; end
          2'd2:    begin wstrb = LANES'(4'b1100) << lane_base; wdata_bus = {(LANES/4){wdata[15:0], 16'h0}}; end
          default: begin wstrb = LANES'(4'b1000) << lane_base; wdata_bus = {(LANES/4){wdata[7:0], 24'h0}}; end
        endcase
      end
      default: ;
    endcase
  end

  // Load extraction and little-endian LWL/LWR merge with the old rt value
  always_comb begin
    ld_result = 32'h0;
    case (op)
      EXE_LB_OP:  ld_result = {{24{byte_v[7]}}, byte_v};
      EXE_LBU_OP: ld_result = {24'h0, byte_v};
      EXE_LH_OP:  ld_result = {{16{half_v[15]}}, half_v};
      EXE_LHU_OP: ld_result = {16'h0, half_v};
      EXE_LW_OP:  ld_result = word_lane;
      EXE_LWL_OP: if (LR_EN) begin
        case (ofs[1:0])
          2'd0:    ld_result = {word_lane[7:0],  rt_old[23:0]};
          2'd1:    ld_result = {word_lane[15:0], rt_old[15:0]};
          2'd2:    ld_result = {word_lane[23:0], rt_old[7:0]};
          default: ld_result = word_lane;
        endcase
      end
      EXE_LWR_OP: if (LR_EN) begin
        case (ofs[1:0])
          2'd0:    ld_result = word_lane;
          2'd1:    ld_result = {rt_old[31:24], word_lane[31:8]};
          2'd2:    ld_result = {rt_old[31:16], word_lane[31:16]};
          default: ld_result = {rt_old[31:8],  word_lane[31:24]};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a split req/addr_ok/data_ok bus.
// Stalls the pipeline while an access is outstanding and drains accepted
// requests that were flushed. Optional macro: UNALIGNED_LR_EN.
module mem_access_unit #(
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_en,
  input  logic [5:0]           op,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          wdata,
  input  logic [31:0]          rt_old,
  input  logic [31:0]          pc,
  input  logic                 flush,
  input  logic                 pipe_adv,
  output logic                 stall_out,
  output logic [31:0]          rdata_out,
  output logic                 adel,
  output logic                 ades,
  output logic [31:0]          bad_addr,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [1:0]           data_size,
  output logic [ADDR_W-1:0]    data_addr,
  output logic [BUS_W/8-1:0]   data_wstrb,
  output logic [BUS_W-1:0]     data_wdata,
  input  logic                 data_addr_ok,
  input  logic                 data_data_ok,
  input  logic [BUS_W-1:0]     data_rdata
);
  import mem_access_unit_pkg::*;

  localparam int OFS_W = $clog2(BUS_W / 8);

  logic [1:0]        state;
  logic              done;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              idle;
  logic              mem_act;
  logic              misal;
  logic              start;
  logic              capture;
  logic [5:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [31:0]       ld_result;

  assign idle    = (state == ST_IDLE);
  assign mem_act = mem_en & (op_is_load(op) | op_is_store(op));
  assign misal   = ~op_is_lr(op) &
                   (((op_size(op) == SZ_WORD) & (addr[1:0] != 2'b00)) |
                    ((op_size(op) == SZ_HALF) & addr[0]));
  assign adel     = mem_act & op_is_load(op) & misal;
  assign ades     = mem_act & op_is_store(op) & misal;
  assign bad_addr = (adel | ades) ? 32'(addr) : pc;

  assign start     = mem_act & ~adel & ~ades & ~flush & ~done & idle;
  assign capture   = (state == ST_WAIT) & data_data_ok;
  assign stall_out = (mem_act & ~adel & ~ades & ~done & ~flush) |
                     (state == ST_REQ) | (state == ST_WAIT);

  // Live fields while issuing from IDLE, registered copies once accepted or pending
  assign sel_op    = idle ? op    : op_q;
  assign sel_addr  = idle ? addr  : addr_q;
  assign sel_wdata = idle ? wdata : wdata_q;

  assign data_req  = ~rst & (start | (state == ST_REQ));
  assign data_wr   = op_is_store(sel_op);
  assign data_size = op_size(sel_op);
  assign data_addr = sel_addr;

  mem_access_unit_align #(.BUS_W(BUS_W)) u_align (
    .op        (sel_op),
    .ofs       (sel_addr[OFS_W-1:0]),
    .wdata     (sel_wdata),
    .rt_old    (rt_old),
    .rdata     (data_rdata),
    .wstrb     (data_wstrb),
    .wdata_bus (data_wdata),
    .ld_result (ld_result)
  );

  // Access FSM: issue, wait for acceptance, wait for data, drain after flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= data_addr_ok ? ST_WAIT : ST_REQ;
        ST_REQ: begin
          if (data_addr_ok)  state <= flush ? ST_DRAIN : ST_WAIT;
          else if (flush)    state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (data_data_ok)  state <= ST_IDLE;
          else if (flush)    state <= ST_DRAIN;
        end
        default:  if (data_data_ok) state <= ST_IDLE;
      endcase
    end
  end

  // Hold the request fields so they stay stable until the bus accepts them
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      op_q    <= op;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Capture load results and block re-issue until the pipeline moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_out <= '0;
      done      <= 1'b0;
    end else begin
      if (capture && op_is_load(op_q)) rdata_out <= ld_result;
      if (capture)       done <= 1'b1;
      else if (pipe_adv) done <= 1'b0;
    end
  end

endmodule
